// File: rtl/stream_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stream_run_ctrl
// Description : Turns host-stream commands into network timestep enables,
//               network clears and sync packets toward the stream sink.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_run_ctrl #(
    parameter int RUN_WIDTH  = 16,
    parameter int CLR_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 arstn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [RUN_WIDTH-1:0] cmd_cnt,
    output logic                 net_en,
    output logic                 net_arstn,
    output logic                 net_valid,
    output logic                 net_last,
    input  logic                 net_ready,
    output logic                 busy
);

    localparam logic [1:0]           c_OP_RUN   = 2'b01;
    localparam logic [1:0]           c_OP_CLR   = 2'b10;
    localparam logic [1:0]           c_OP_SNC   = 2'b11;
    localparam logic [RUN_WIDTH-1:0] c_RUN_ONE  = RUN_WIDTH'(1);
    localparam logic [RUN_WIDTH-1:0] c_RUN_ZERO = '0;
    localparam logic [7:0]           c_CLR_LOAD = 8'(CLR_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_STEP  = 3'd1,
        ST_OUT   = 3'd2,
        ST_CLEAR = 3'd3,
        ST_SYNC  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [RUN_WIDTH-1:0] r_remaining;
    logic [RUN_WIDTH-1:0] w_next_remaining;
    logic [7:0]           r_clr_cnt;
    logic [7:0]           w_next_clr_cnt;

    logic r_cmd_ready;
    logic r_net_en;
    logic r_net_arstn;
    logic r_net_valid;
    logic r_net_last;
    logic r_busy;

    logic w_accept;
    logic w_handshake;

    assign w_accept    = cmd_valid && r_cmd_ready;
    assign w_handshake = r_net_valid && net_ready;

    always_comb begin
        w_next_state     = r_state;
        w_next_remaining = r_remaining;
        w_next_clr_cnt   = r_clr_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (cmd_op)
                        c_OP_RUN: begin
                            if (cmd_cnt != c_RUN_ZERO) begin
                                w_next_state     = ST_STEP;
                                w_next_remaining = cmd_cnt;
                            end
                        end
                        c_OP_CLR: begin
                            w_next_state   = ST_CLEAR;
                            w_next_clr_cnt = c_CLR_LOAD;
                        end
                        c_OP_SNC: w_next_state = ST_SYNC;
                        default:  w_next_state = ST_IDLE;
                    endcase
                end
            end
            ST_STEP: w_next_state = ST_OUT;
            ST_OUT: begin
                if (w_handshake) begin
                    w_next_remaining = r_remaining - c_RUN_ONE;
                    w_next_state     = (r_remaining == c_RUN_ONE) ? ST_IDLE : ST_STEP;
                end
            end
            ST_CLEAR: begin
                w_next_clr_cnt = r_clr_cnt - 8'd1;
                if (r_clr_cnt <= 8'd1) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (w_handshake) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so every output is a flop
    // that is already correct in the first cycle of the new state.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_clr_cnt   <= '0;
            r_cmd_ready <= 1'b0;
            r_net_en    <= 1'b0;
            r_net_arstn <= 1'b1;
            r_net_valid <= 1'b0;
            r_net_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_remaining <= w_next_remaining;
            r_clr_cnt   <= w_next_clr_cnt;
            r_cmd_ready <= (w_next_state == ST_IDLE) && !w_accept;
            r_net_en    <= (w_next_state == ST_STEP);
            r_net_arstn <= (w_next_state != ST_CLEAR);
            r_net_valid <= (w_next_state == ST_OUT) || (w_next_state == ST_SYNC);
            r_net_last  <= (w_next_state == ST_SYNC);
            r_busy      <= (w_next_state != ST_IDLE);
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign net_en    = r_net_en;
    assign net_arstn = r_net_arstn;
    assign net_valid = r_net_valid;
    assign net_last  = r_net_last;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_stream_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_stream_run_ctrl
// Description : Self-checking bench for stream_run_ctrl using a
//               command-to-cycle-trace reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_run_ctrl;

    localparam int CLR_CYCLES = 2;
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_RUN = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_SNC = 2'b11;

    // {cmd_ready, net_en, net_arstn, net_valid, net_last, busy}
    localparam logic [5:0] V_RST  = 6'b001000;
    localparam logic [5:0] V_IDLE = 6'b101000;
    localparam logic [5:0] V_STEP = 6'b011001;
    localparam logic [5:0] V_PKT  = 6'b001101;
    localparam logic [5:0] V_SNC  = 6'b001111;
    localparam logic [5:0] V_CLR  = 6'b000001;
    localparam logic [5:0] V_NOP  = 6'b001000;

    typedef struct packed {
        logic [5:0] o;
        logic       rdy;
    } ent_t;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [15:0] cmd_cnt = 16'd0;
    logic        net_en;
    logic        net_arstn;
    logic        net_valid;
    logic        net_last;
    logic        net_ready = 1'b0;
    logic        busy;

    int tests = 0;
    int fails = 0;

    stream_run_ctrl #(.RUN_WIDTH(16), .CLR_CYCLES(CLR_CYCLES)) dut (
        .clk       (clk),
        .arstn     (arstn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .net_en    (net_en),
        .net_arstn (net_arstn),
        .net_valid (net_valid),
        .net_last  (net_last),
        .net_ready (net_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] outs();
        return {cmd_ready, net_en, net_arstn, net_valid, net_last, busy};
    endfunction

    task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Expands one command into its expected per-cycle output trace, then
    // plays it while the DUT is fed junk commands and random idle-ready.
    // stall < 0 picks random backpressure per packet; otherwise the first
    // packet stalls exactly 'stall' cycles and later ones not at all.
    task automatic do_cmd(input string tag, input logic [1:0] op, input logic [15:0] cnt,
                          input int stall);
        ent_t q[$];
        ent_t e;
        int   s;
        int   n;
        check({tag, "_idle"}, outs(), V_IDLE);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = cnt;
        net_ready = 1'($urandom);
        n = int'(cnt);
        if (op == OP_RUN && n > 0) begin
            for (int i = 0; i < n; i++) begin
                e.o = V_STEP; e.rdy = 1'b0; q.push_back(e);
                s = (stall < 0) ? int'($urandom_range(0, 3)) : ((i == 0) ? stall : 0);
                for (int j = 0; j <= s; j++) begin
                    e.o = V_PKT; e.rdy = (j == s); q.push_back(e);
                end
            end
        end else if (op == OP_CLR) begin
            for (int i = 0; i < CLR_CYCLES; i++) begin
                e.o = V_CLR; e.rdy = 1'b0; q.push_back(e);
            end
        end else if (op == OP_SNC) begin
            s = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
            for (int j = 0; j <= s; j++) begin
                e.o = V_SNC; e.rdy = (j == s); q.push_back(e);
            end
        end else begin
            e.o = V_NOP; e.rdy = 1'b0; q.push_back(e);
        end
        foreach (q[k]) begin
            @(posedge clk); #1;
            check(tag, outs(), q[k].o);
            cmd_valid = 1'($urandom);
            cmd_op    = 2'($urandom);
            cmd_cnt   = 16'($urandom);
            net_ready = q[k].o[2] ? q[k].rdy : 1'($urandom);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    initial begin
        // Reset and first idle
        repeat (3) @(posedge clk);
        #1;
        check("reset", outs(), V_RST);
        arstn = 1'b1;
        #1;
        check("post_release", outs(), V_RST);
        @(posedge clk); #1;
        check("first_ready", outs(), V_IDLE);

        // Directed sequences
        do_cmd("run3", OP_RUN, 16'd3, 0);
        do_cmd("run2_stall", OP_RUN, 16'd2, 4);
        do_cmd("clr", OP_CLR, 16'd0, 0);
        do_cmd("snc", OP_SNC, 16'd0, 2);
        do_cmd("run0", OP_RUN, 16'd0, 0);
        do_cmd("nop", OP_NOP, 16'd7, 0);

        // Randomized command stream
        for (int i = 0; i < 40; i++) begin
            do_cmd("rand", 2'($urandom), 16'($urandom_range(0, 5)), -1);
        end

        // Reset after the third handshake of a 10-step run
        check("mr_idle", outs(), V_IDLE);
        cmd_valid = 1'b1; cmd_op = OP_RUN; cmd_cnt = 16'd10; net_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            cmd_valid = 1'b0;
            check("mr_run", outs(), (k % 2 == 1) ? V_STEP : V_PKT);
        end
        @(posedge clk); #1;
        arstn = 1'b0;
        #1;
        check("mr_async", outs(), V_RST);
        repeat (2) @(posedge clk);
        #1;
        check("mr_hold", outs(), V_RST);
        arstn = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            check("mr_after", outs(), V_IDLE);
        end

        // Reset in the middle of a clear releases net_arstn at once
        cmd_valid = 1'b1; cmd_op = OP_CLR;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check("mc_clear", outs(), V_CLR);
        arstn = 1'b0;
        #1;
        check("mc_async", outs(), V_RST);
        @(posedge clk); #1;
        arstn = 1'b1;
        @(posedge clk); #1;
        check("mc_after", outs(), V_IDLE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
